// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with a valid/ready output.
// Define UART_RX_PARITY_EN to add an even-parity bit (8E1) and the o_parity_err pulse.
`timescale 1ns/1ps

module uart_rx_fifo #(
   parameter int CLK_HZ     = 12_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_rx,
   output logic [7:0]                    o_data,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic                          o_frame_err,
   output logic                          o_overrun,
`ifdef UART_RX_PARITY_EN
   output logic                          o_parity_err,
`endif
   output logic [$clog2(FIFO_DEPTH):0]   o_count
);

   // state   | meaning
   // IDLE    | waiting for a falling edge on the synchronised line
   // START   | half a bit-time in; confirm the start bit is still low
   // DATA    | sampling 8 data bits, LSB first, mid-bit
   // PARITY  | sampling the even-parity bit (parity build only)
   // STOP    | sampling the stop bit, then push / flag error
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int CLKS_PER_BIT = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int PTR_W        = $clog2(FIFO_DEPTH);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

   logic rx_meta, rx_sync, rx_hist;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_hist <= 1'b1;
      end else begin
         rx_meta <= i_rx;
         rx_sync <= rx_meta;
         rx_hist <= rx_sync;
      end
   end

   state_t           state_q, state_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic [2:0]       idx_q, idx_nxt;
   logic [7:0]       shift_q, shift_nxt;
   logic             stop_hit;
   logic             par_q, par_nxt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
      end else begin
         state_q <= state_nxt;
         cnt_q   <= cnt_nxt;
         idx_q   <= idx_nxt;
         shift_q <= shift_nxt;
         par_q   <= par_nxt;
      end
   end

   always_comb begin
      state_nxt = state_q;
      cnt_nxt   = cnt_q;
      idx_nxt   = idx_q;
      shift_nxt = shift_q;
      par_nxt   = par_q;
      stop_hit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rx_hist && !rx_sync) begin
               cnt_nxt   = CNT_HALF;
               state_nxt = START;
            end
         end
         START: begin
            if (cnt_q == '0) begin
               if (!rx_sync) begin
                  cnt_nxt   = CNT_FULL;
                  idx_nxt   = '0;
                  state_nxt = DATA;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == '0) begin
               shift_nxt[idx_q] = rx_sync;
               cnt_nxt          = CNT_FULL;
               if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  idx_nxt = idx_q + 3'd1;
               end
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         PARITY: begin
            if (cnt_q == '0) begin
               par_nxt   = rx_sync;
               cnt_nxt   = CNT_FULL;
               state_nxt = STOP;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == '0) begin
               stop_hit  = 1'b1;
               state_nxt = IDLE;
            end else begin
               cnt_nxt = cnt_q - CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   logic byte_ok, full, pop, push, overrun_c;
`ifdef UART_RX_PARITY_EN
   logic par_bad;
   assign par_bad = par_q != ^shift_q;
   assign byte_ok = stop_hit && rx_sync && !par_bad;
`else
   assign byte_ok = stop_hit && rx_sync;
`endif

   // A same-cycle pop frees a slot, so a full FIFO can still accept the byte.
   assign full      = o_count == (PTR_W + 1)'(FIFO_DEPTH);
   assign pop       = o_valid && i_ready;
   assign push      = byte_ok && (!full || pop);
   assign overrun_c = byte_ok && full && !pop;

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
   logic [PTR_W:0]   cnt_after_pop, count_nxt;
   logic [7:0]       head_nxt;

   assign rd_nxt        = pop ? rd_ptr + PTR_W'(1) : rd_ptr;
   assign cnt_after_pop = pop ? o_count - (PTR_W + 1)'(1) : o_count;
   assign count_nxt     = push ? cnt_after_pop + (PTR_W + 1)'(1) : cnt_after_pop;
   // When the FIFO drains to empty this cycle, the incoming byte bypasses memory into the head.
   assign head_nxt      = (push && cnt_after_pop == '0) ? shift_q : mem[rd_nxt];

   always_ff @(posedge i_clk) begin
      if (push) mem[wr_ptr] <= shift_q;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         o_count     <= '0;
         o_valid     <= 1'b0;
         o_data      <= '0;
         o_frame_err <= 1'b0;
         o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= 1'b0;
`endif
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr      <= rd_nxt;
         o_count     <= count_nxt;
         o_valid     <= count_nxt != '0;
         if (count_nxt != '0) o_data <= head_nxt;
         o_frame_err <= stop_hit && !rx_sync;
         o_overrun   <= overrun_c;
`ifdef UART_RX_PARITY_EN
         o_parity_err <= stop_hit && rx_sync && par_bad;
`endif
      end
   end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are driven bit-by-bit at 104 clocks per bit.
`timescale 1ns/1ps

module tb_uart_rx_fifo;

   localparam int CPB = 104;

   logic       clk = 1'b0;
   logic       rst, rx, ready;
   logic [7:0] o_data;
   logic       o_valid, o_frame_err, o_overrun;
   logic [4:0] o_count;
`ifdef UART_RX_PARITY_EN
   logic       o_parity_err;
`endif

   uart_rx_fifo dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_rx        (rx),
      .o_data      (o_data),
      .o_valid     (o_valid),
      .i_ready     (ready),
      .o_frame_err (o_frame_err),
      .o_overrun   (o_overrun),
`ifdef UART_RX_PARITY_EN
      .o_parity_err(o_parity_err),
`endif
      .o_count     (o_count)
   );

   always #42 clk = ~clk;

   int         n_chk  = 0;
   int         n_pass = 0;
   int         n_ferr = 0;
   int         n_ovr  = 0;
   int         n_perr = 0;
   logic [7:0] log_q[$];

   always @(negedge clk) begin
      if (!rst) begin
         if (o_valid && ready) log_q.push_back(o_data);
         if (o_frame_err) n_ferr++;
         if (o_overrun) n_ovr++;
`ifdef UART_RX_PARITY_EN
         if (o_parity_err) n_perr++;
`endif
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
`ifdef UART_RX_PARITY_EN
      rx = ^d;
      tick(CPB);
`endif
      rx = stop;
      tick(CPB);
      rx = 1'b1;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_par(input logic [7:0] d, input logic par, input logic stop);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         tick(CPB);
      end
      rx = par;
      tick(CPB);
      rx = stop;
      tick(CPB);
      rx = 1'b1;
   endtask
`endif

   initial begin
      #(84 * 95000);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int ferr0;
      rst = 1'b1; rx = 1'b1; ready = 1'b0;
      tick(3);
      rst = 1'b0;
      tick(1);
      chk("rst_valid", 32'(o_valid), 32'h0);
      chk("rst_data",  32'(o_data),  32'h0);
      chk("rst_count", 32'(o_count), 32'h0);

      // single byte, not consumed
      send(8'h41, 1'b1);
      chk("t1_valid", 32'(o_valid), 32'h1);
      chk("t1_data",  32'(o_data),  32'h41);
      chk("t1_count", 32'(o_count), 32'h1);
      chk("t1_ferr",  32'(n_ferr),  32'h0);
      chk("t1_ovr",   32'(n_ovr),   32'h0);
      ready = 1'b1;
      tick(2);
      ready = 1'b0;
      chk("t1_pop_n",    32'(log_q.size()), 32'h1);
      chk("t1_pop_data", 32'(log_q[0]),     32'h41);
      chk("t1_empty",    32'(o_count),      32'h0);
      log_q.delete();

      // back-to-back frames with consumer ready
      ready = 1'b1;
      send(8'h55, 1'b1);
      send(8'h0D, 1'b1);
      send(8'hFF, 1'b1);
      tick(5);
      chk("t2_n",     32'(log_q.size()), 32'h3);
      chk("t2_b0",    32'(log_q[0]),     32'h55);
      chk("t2_b1",    32'(log_q[1]),     32'h0D);
      chk("t2_b2",    32'(log_q[2]),     32'hFF);
      chk("t2_count", 32'(o_count),      32'h0);
      log_q.delete();

      // overflow: 17 bytes into a 16-deep FIFO
      ready = 1'b0;
      for (int i = 0; i <= 16; i++) send(8'(i), 1'b1);
      chk("t3_count", 32'(o_count), 32'h10);
      chk("t3_ovr",   32'(n_ovr),   32'h1);
      chk("t3_ferr",  32'(n_ferr),  32'h0);
      ready = 1'b1;
      tick(20);
      ready = 1'b0;
      chk("t3_n", 32'(log_q.size()), 32'h10);
      for (int i = 0; i < 16; i++) chk($sformatf("t3_drain%0d", i), 32'(log_q[i]), 32'(i));
      chk("t3_empty", 32'(o_count), 32'h0);
      log_q.delete();

      // glitch, then a frame with a low stop bit
      ferr0 = n_ferr;
      rx = 1'b0;
      tick(2);
      rx = 1'b1;
      tick(300);
      chk("t4_glitch_count", 32'(o_count), 32'h0);
      send(8'h30, 1'b0);
      tick(5);
      chk("t4_ferr",  32'(n_ferr - ferr0), 32'h1);
      chk("t4_valid", 32'(o_valid),        32'h0);
      chk("t4_count", 32'(o_count),        32'h0);

      // reset in the middle of 0x7E with two bytes queued
      send(8'h11, 1'b1);
      send(8'h22, 1'b1);
      chk("t5_queued", 32'(o_count), 32'h2);
      rx = 1'b0; tick(CPB);
      rx = 1'b0; tick(CPB);
      rx = 1'b1; tick(CPB);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("t5_rst_valid", 32'(o_valid), 32'h0);
      chk("t5_rst_count", 32'(o_count), 32'h0);
      ferr0 = n_ferr;
      tick(CPB * 12);
      chk("t5_idle_ferr",  32'(n_ferr - ferr0), 32'h0);
      chk("t5_idle_count", 32'(o_count),        32'h0);
      send(8'h31, 1'b1);
      chk("t5_valid", 32'(o_valid), 32'h1);
      chk("t5_data",  32'(o_data),  32'h31);
      chk("t5_count", 32'(o_count), 32'h1);
      chk("t5_nopop", 32'(log_q.size()), 32'h0);

`ifdef UART_RX_PARITY_EN
      ready = 1'b1;
      tick(2);
      ready = 1'b0;
      log_q.delete();
      ferr0 = n_ferr;
      send_par(8'h03, 1'b0, 1'b1);
      chk("t6_good_count", 32'(o_count), 32'h1);
      chk("t6_good_data",  32'(o_data),  32'h03);
      chk("t6_good_perr",  32'(n_perr),  32'h0);
      send_par(8'h03, 1'b1, 1'b1);
      chk("t6_bad_count", 32'(o_count), 32'h1);
      chk("t6_bad_perr",  32'(n_perr),  32'h1);
      send_par(8'h03, 1'b1, 1'b0);
      tick(3);
      chk("t6_both_perr", 32'(n_perr),         32'h1);
      chk("t6_both_ferr", 32'(n_ferr - ferr0), 32'h1);
      chk("t6_both_count", 32'(o_count),       32'h1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
